// File: rtl/mont_pkg.sv
// Shared constants, FSM state and op-phase types for the Montgomery exponent controller.
// Optional build macro: MONT_EXP_SKIP_LEADING_EN (skip leading zero exponent bits).
package mont_pkg;

  localparam int K = 8;
  localparam int E_W = 8;
  localparam int IW = $clog2(E_W);
  localparam logic [K-1:0] M = 8'd239;
  localparam logic [K-1:0] R1 = 8'd17;
  localparam logic [K-1:0] R2 = 8'd50;

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    SQR,
    MUL,
    EXIT
  } state_t;

  typedef enum logic [1:0] {
    PH_SCAN,
    PH_ISSUE,
    PH_WAIT
  } phase_t;

endpackage

// File: rtl/mont_exp_ctrl_if.sv
// Host and monmul bundle for mont_exp_ctrl.
// master = host, slave = controller, mm = monmul responder.
interface mont_exp_ctrl_if;
  import mont_pkg::*;

  logic start;
  logic [K-1:0] x;
  logic [E_W-1:0] e;
  logic [K-1:0] z;
  logic done;
  logic busy;
  logic [K-1:0] mm_x;
  logic [K-1:0] mm_y;
  logic mm_start;
  logic [K-1:0] mm_z;
  logic mm_done;

  modport master (
    output start, x, e,
    input z, done, busy
  );

  modport slave (
    input start, x, e, mm_z, mm_done,
    output z, done, busy, mm_x, mm_y, mm_start
  );

  modport mm (
    input mm_x, mm_y, mm_start,
    output mm_z, mm_done
  );

endinterface

// File: rtl/monmul.sv
// Bit-serial Montgomery multiplier: z = a*b*2^-K mod M.
// K iterations after start, then a one-cycle done pulse with z.
module monmul #(
  parameter int K = 8,
  parameter logic [K-1:0] M = 8'd239
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  output logic [K-1:0] z,
  output logic         done
);

  localparam int CW = $clog2(K);

  logic [K-1:0] a_q;
  logic [K-1:0] b_q;
  logic [K+1:0] t_q;
  logic [K+1:0] t_add;
  logic [K+1:0] t_odd;
  logic [K+1:0] t_nx;
  logic [CW-1:0] cnt_q;
  logic run_q;

  // t stays below 2M, so K+2 bits hold t + b + M
  always_comb begin
    t_add = t_q + (a_q[0] ? {2'b00, b_q} : '0);
    t_odd = t_add + (t_add[0] ? {2'b00, M} : '0);
    t_nx = t_odd >> 1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q <= '0;
      b_q <= '0;
      t_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      done <= 1'b0;
      z <= '0;
    end else begin
      done <= 1'b0;
      if (run_q) begin
        t_q <= t_nx;
        a_q <= a_q >> 1;
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == CW'(K-1)) begin
          run_q <= 1'b0;
          done <= 1'b1;
          z <= (t_nx >= {2'b00, M}) ? K'(t_nx - {2'b00, M}) : K'(t_nx);
        end
      end else if (start) begin
        a_q <= a;
        b_q <= b;
        t_q <= '0;
        cnt_q <= '0;
        run_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mont_exp_ctrl.sv
// Modular exponentiation controller z = x^e mod M driving one external monmul.
// Optional build macro: MONT_EXP_SKIP_LEADING_EN (skip leading zero exponent bits).
module mont_exp_ctrl
  import mont_pkg::*;
(
  input logic clk,
  input logic reset_n,
  mont_exp_ctrl_if.slave io
);

  state_t state_q, state_d;
  phase_t phase_q, phase_d;
  logic [IW-1:0] i_q, i_d;
  logic [K-1:0] acc_q, acc_d;
  logic [K-1:0] xb_q, xb_d;
  logic [K-1:0] xin_q, xin_d;
  logic [E_W-1:0] ein_q, ein_d;
  logic [K-1:0] z_q, z_d;
  logic done_q, done_d;
  logic go;
  logic [K-1:0] op_a;
  logic [K-1:0] op_b;
  logic last;
  logic cur_bit;
  state_t nb_state;
  logic [IW-1:0] nb_i;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    i_d = i_q;
    acc_d = acc_q;
    xb_d = xb_q;
    xin_d = xin_q;
    ein_d = ein_q;
    z_d = z_q;
    done_d = 1'b0;
    go = 1'b0;
    op_a = '0;
    op_b = '0;
    last = (i_q == '0);
    cur_bit = ein_q[i_q];
    nb_state = last ? EXIT : SQR;
    nb_i = last ? i_q : i_q - 1'b1;

    case (state_q)
      CONV: begin op_a = xin_q; op_b = R2; end
      SQR: begin op_a = acc_q; op_b = acc_q; end
      MUL: begin op_a = acc_q; op_b = xb_q; end
      EXIT: begin op_a = acc_q; op_b = K'(1); end
      default: ;
    endcase

    if (state_q == IDLE) begin
      // the done cycle still counts as busy for new requests
      if (io.start && !done_q) begin
        xin_d = io.x;
        ein_d = io.e;
        i_d = IW'(E_W-1);
        state_d = CONV;
`ifdef MONT_EXP_SKIP_LEADING_EN
        phase_d = PH_SCAN;
`else
        phase_d = PH_ISSUE;
`endif
      end
    end else begin
      unique case (phase_q)
        PH_SCAN: begin
          if (cur_bit || last) phase_d = PH_ISSUE;
          else i_d = i_q - 1'b1;
        end
        PH_ISSUE: begin
          go = 1'b1;
          phase_d = PH_WAIT;
        end
        PH_WAIT: begin
          if (io.mm_done) begin
            phase_d = PH_ISSUE;
            unique case (state_q)
              CONV: begin
                xb_d = io.mm_z;
                acc_d = R1;
`ifdef MONT_EXP_SKIP_LEADING_EN
                state_d = cur_bit ? MUL : EXIT;
`else
                state_d = SQR;
`endif
              end
              SQR: begin
                acc_d = io.mm_z;
                if (cur_bit) begin
                  state_d = MUL;
                end else begin
                  state_d = nb_state;
                  i_d = nb_i;
                end
              end
              MUL: begin
                acc_d = io.mm_z;
                state_d = nb_state;
                i_d = nb_i;
              end
              EXIT: begin
                z_d = io.mm_z;
                done_d = 1'b1;
                state_d = IDLE;
              end
              default: state_d = IDLE;
            endcase
          end
        end
        default: phase_d = PH_ISSUE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      phase_q <= PH_ISSUE;
      i_q <= '0;
      acc_q <= '0;
      xb_q <= '0;
      xin_q <= '0;
      ein_q <= '0;
      z_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      i_q <= i_d;
      acc_q <= acc_d;
      xb_q <= xb_d;
      xin_q <= xin_d;
      ein_q <= ein_d;
      z_q <= z_d;
      done_q <= done_d;
    end
  end

  assign io.z = z_q;
  assign io.done = done_q;
  assign io.busy = (state_q != IDLE);
  assign io.mm_start = go;
  assign io.mm_x = op_a;
  assign io.mm_y = op_b;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Self-checking bench: mont_exp_ctrl beside monmul #(8,239) against a modexp reference model.
// Build with MONT_EXP_SKIP_LEADING_EN defined to check the leading-zero-skip variant.
module tb_mont_exp_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int mm_cnt = 0;

  mont_exp_ctrl_if io ();

  mont_exp_ctrl dut (
    .clk(clk),
    .reset_n(reset_n),
    .io(io)
  );

  monmul #(.K(8), .M(8'd239)) u_mm (
    .clk(clk),
    .reset_n(reset_n),
    .start(io.mm_start),
    .a(io.mm_x),
    .b(io.mm_y),
    .z(io.mm_z),
    .done(io.mm_done)
  );

  always #50 clk = ~clk;

  always @(negedge clk) if (io.mm_start === 1'b1) mm_cnt++;

  function automatic int ref_exp(int xv, int ev);
    longint r = 1;
    longint b = xv;
    for (int k = 0; k < 8; k++) begin
      if (((ev >> k) & 1) == 1) r = (r * b) % 239;
      b = (b * b) % 239;
    end
    return int'(r);
  endfunction

  function automatic int ref_ops(int ev);
    int pop = 0;
    int msb = 0;
    for (int k = 0; k < 8; k++) begin
      if (((ev >> k) & 1) == 1) begin
        pop++;
        msb = k;
      end
    end
`ifdef MONT_EXP_SKIP_LEADING_EN
    return (ev == 0) ? 2 : 2 + msb + pop;
`else
    return 2 + 8 + pop + 0 * msb;
`endif
  endfunction

  task automatic wait_done(output bit to);
    to = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      if (io.done === 1'b1) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_op(input int xv, input int ev, output int zv, output int ops,
                        output logic bsy, output logic dnext, output bit to);
    @(negedge clk);
    io.x = xv[7:0];
    io.e = ev[7:0];
    io.start = 1'b1;
    mm_cnt = 0;
    @(negedge clk);
    io.start = 1'b0;
    wait_done(to);
    zv = int'(io.z);
    ops = mm_cnt;
    bsy = io.busy;
    @(negedge clk);
    dnext = io.done;
  endtask

  task automatic check_op(input string nm, input int xv, input int ev, input int zexp);
    int zv, ops;
    logic bsy, dn;
    bit to;
    run_op(xv, ev, zv, ops, bsy, dn, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL %s timeout: no done for x=%0d e=%0d", nm, xv, ev);
    end
    checks++;
    if (zv !== zexp) begin
      errors++;
      $display("FAIL %s z: x=%0d e=%0d got %0d want %0d", nm, xv, ev, zv, zexp);
    end
    checks++;
    if (ops !== ref_ops(ev)) begin
      errors++;
      $display("FAIL %s ops: e=%0d got %0d want %0d", nm, ev, ops, ref_ops(ev));
    end
    checks++;
    if (bsy !== 1'b0 || dn !== 1'b0) begin
      errors++;
      $display("FAIL %s done/busy: busy@done=%b done_next=%b want 0/0", nm, bsy, dn);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #1;
    checks++;
    if (io.z !== 8'd0 || io.done !== 1'b0 || io.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset host: z=%0d done=%b busy=%b want 0", io.z, io.done, io.busy);
    end
    checks++;
    if (io.mm_start !== 1'b0 || io.mm_x !== 8'd0 || io.mm_y !== 8'd0) begin
      errors++;
      $display("FAIL reset mm: start=%b x=%0d y=%0d want 0", io.mm_start, io.mm_x, io.mm_y);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_directed;
    check_op("e1", 202, 1, 202);
    check_op("e3", 202, 3, 15);
    check_op("e2", 202, 2, 174);
    check_op("neg1", 238, 2, 1);
    check_op("x0", 0, 5, 0);
    check_op("e0", 123, 0, 1);
    check_op("x0e0", 0, 0, 1);
    check_op("emax", 202, 255, ref_exp(202, 255));
  endtask

  task automatic test_random;
    int xv, ev;
    for (int n = 0; n < 20; n++) begin
      xv = int'($urandom_range(0, 238));
      ev = int'($urandom_range(0, 255));
      check_op("rand", xv, ev, ref_exp(xv, ev));
    end
  endtask

  task automatic test_hold;
    logic [7:0] zh;
    check_op("hold", 202, 3, 15);
    zh = io.z;
    io.x = 8'd7;
    io.e = 8'd9;
    repeat (5) @(negedge clk);
    checks++;
    if (io.z !== 8'd15 || io.busy !== 1'b0) begin
      errors++;
      $display("FAIL hold: z=%0d busy=%b want 15/0 (was %0d)", io.z, io.busy, zh);
    end
  endtask

  task automatic test_back_to_back;
    bit to;
    int ops;
    @(negedge clk);
    io.x = 8'd202;
    io.e = 8'd3;
    io.start = 1'b1;
    mm_cnt = 0;
    @(negedge clk);
    io.start = 1'b0;
    repeat (3) @(negedge clk);
    io.x = 8'd5;
    io.e = 8'd7;
    io.start = 1'b1;
    @(negedge clk);
    io.start = 1'b0;
    io.x = 8'd170;
    io.e = 8'd85;
    wait_done(to);
    ops = mm_cnt;
    checks++;
    if (to || io.z !== 8'd15) begin
      errors++;
      $display("FAIL busy_restart z: got %0d want 15 timeout=%0d", io.z, to);
    end
    checks++;
    if (ops !== ref_ops(3)) begin
      errors++;
      $display("FAIL busy_restart ops: got %0d want %0d", ops, ref_ops(3));
    end
    io.x = 8'd9;
    io.e = 8'd9;
    io.start = 1'b1;
    @(negedge clk);
    io.start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (io.busy !== 1'b0 || mm_cnt !== ops || io.z !== 8'd15) begin
      errors++;
      $display("FAIL done_cycle_start: busy=%b ops=%0d z=%0d want 0/%0d/15",
               io.busy, mm_cnt, io.z, ops);
    end
  endtask

  task automatic test_reset_mid;
    bit to;
    to = 1'b1;
    @(negedge clk);
    io.x = 8'd202;
    io.e = 8'd3;
    io.start = 1'b1;
    mm_cnt = 0;
    @(negedge clk);
    io.start = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (mm_cnt >= 2) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (to) begin
      errors++;
      $display("FAIL reset_mid timeout: mm_start count %0d want 2", mm_cnt);
    end
    #20;
    reset_n = 1'b0;
    #1;
    checks++;
    if (io.busy !== 1'b0 || io.done !== 1'b0 || io.mm_start !== 1'b0 || io.z !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b mm_start=%b z=%0d want 0",
               io.busy, io.done, io.mm_start, io.z);
    end
    @(negedge clk);
    reset_n = 1'b1;
    check_op("after_reset", 202, 2, 174);
  endtask

  initial begin
    io.start = 1'b0;
    io.x = '0;
    io.e = '0;
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
